// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered multi-cycle ALU: the 4-bit opcode map,
// the controller state encoding and the mode selector for the iterative
// multiply/divide core.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Opcode map; 0000-1100 are the original single-cycle ops,
  // 1101-1111 reuse the previously dead encodings for iterative ops.
  localparam logic [3:0] OP_B     = 4'b0000;
  localparam logic [3:0] OP_B4    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_ADDAL = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_AND   = 4'b1010;
  localparam logic [3:0] OP_OR    = 4'b1011;
  localparam logic [3:0] OP_XOR   = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  // Controller states: IDLE handles all single-cycle work, MUL/DIV wait on
  // the iterative core.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  // Which result the iterative core should produce.
  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } mdMode_t;

  // True for the opcodes that need the iterative core.
  function automatic logic isIterOp(input logic [3:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIVU) || (opc == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// -----------------------------------------------------------------------------
// alu_iter_muldiv
// Iterative WIDTH-cycle core: radix-2 shift-add multiply (low WIDTH bits) and
// restoring unsigned division (quotient or remainder), one bit per cycle.
// Ports:
//   clk_i     rising-edge clock
//   reset_i   synchronous active-high reset, abandons any running operation
//   start_i   load operands and begin (pulse, only while idle)
//   mode_i    MD_MUL / MD_DIVU / MD_REMU
//   a_i, b_i  operands (multiplicand/multiplier or dividend/divisor)
//   done_o    high during the final iteration cycle; result_o valid then
//   result_o  final result, meaningful only while done_o is high
// -----------------------------------------------------------------------------
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  mdMode_t          mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // opA_q: multiplicand (MUL) or dividend/quotient shift register (DIV)
  // opB_q: multiplier (MUL) or divisor (DIV)
  // acc_q: product accumulator (MUL) or partial remainder (DIV)
  logic             busy_q;
  logic [CNT_W-1:0] count_q;
  mdMode_t          mode_q;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] remTrial;

  // One iteration step for whichever mode is running. For division the
  // partial remainder is shifted left with the next dividend bit and the
  // divisor is subtracted only when it fits. A zero divisor always "fits",
  // which naturally yields an all-ones quotient and a remainder equal to
  // the dividend, so no special case is needed.
  always_comb begin
    opA_d    = opA_q;
    opB_d    = opB_q;
    acc_d    = acc_q;
    shifted  = {acc_q, opA_q[WIDTH-1]};
    fits     = (shifted >= {1'b0, opB_q});
    remTrial = shifted[WIDTH-1:0] - opB_q;
    if (mode_q == MD_MUL) begin
      acc_d = opB_q[0] ? (acc_q + opA_q) : acc_q;
      opA_d = opA_q << 1;
      opB_d = opB_q >> 1;
    end else begin
      acc_d = fits ? remTrial : shifted[WIDTH-1:0];
      opA_d = {opA_q[WIDTH-2:0], fits};
    end
  end

  // The final iteration's next-state values are the answer, so the
  // controller can capture them on the same edge the core goes idle.
  always_comb begin
    done_o = busy_q && (count_q == LAST);
    unique case (mode_q)
      MD_MUL:  result_o = acc_d;
      MD_REMU: result_o = acc_d;
      default: result_o = opA_d;
    endcase
  end

  // Operand/iteration registers. start_i loads fresh operands; afterwards
  // the core steps once per cycle for exactly WIDTH cycles.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q  <= 1'b0;
      count_q <= '0;
      mode_q  <= MD_MUL;
      opA_q   <= '0;
      opB_q   <= '0;
      acc_q   <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      count_q <= '0;
      mode_q  <= mode_i;
      opA_q   <= a_i;
      opB_q   <= b_i;
      acc_q   <= '0;
    end else if (busy_q) begin
      opA_q <= opA_d;
      opB_q <= opB_d;
      acc_q <= acc_d;
      if (count_q == LAST) begin
        busy_q  <= 1'b0;
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
// Registered ALU between operand fetch and writeback. Thirteen ops complete in
// one cycle; MUL/DIVU/REMU run on an iterative core for WIDTH cycles while
// upstream is stalled. Both sides use valid/ready handshakes.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid / in_ready   operand handshake (A, B, op sampled on accept)
//   A, B                  operands
//   op                    4-bit opcode (see alu_pkg)
//   out_valid / out_ready result handshake
//   Out                   result register
//   Z, N, C, V            flag registers (only SUB/SLT/SLTU set them)
// -----------------------------------------------------------------------------
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;

  logic             accept;
  logic [SHAMT_W-1:0] sh;
  logic [WIDTH-1:0] diff;
  logic             flagZ, flagN, flagC, flagV;
  logic [WIDTH-1:0] aluRes;
  logic [3:0]       aluFlags;

  logic             subStart;
  mdMode_t          subMode;
  logic             subDone;
  logic [WIDTH-1:0] subResult;

  assign in_ready = (state_q == IDLE) && (!outValid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath. Flags always come from A-B; SLT uses N^V so the
  // signed compare stays correct when the subtraction overflows.
  always_comb begin
    sh       = B[SHAMT_W-1:0];
    diff     = A - B;
    flagZ    = (diff == '0);
    flagN    = diff[WIDTH-1];
    flagC    = (A < B);
    flagV    = (A[WIDTH-1] ^ B[WIDTH-1]) & (A[WIDTH-1] ^ diff[WIDTH-1]);
    aluRes   = '0;
    aluFlags = 4'b0000;
    case (op)
      OP_B:     aluRes = B;
      OP_B4:    aluRes = B + WIDTH'(4);
      OP_ADD:   aluRes = A + B;
      OP_SUB: begin
        aluRes   = diff;
        aluFlags = {flagZ, flagN, flagC, flagV};
      end
      OP_ADDAL: aluRes = (A + B) & ~WIDTH'(1);
      OP_SLL:   aluRes = A << sh;
      OP_SRL:   aluRes = A >> sh;
      OP_SRA:   aluRes = $signed(A) >>> sh;
      OP_SLT: begin
        aluRes   = {{(WIDTH-1){1'b0}}, flagN ^ flagV};
        aluFlags = {flagZ, flagN, flagC, flagV};
      end
      OP_SLTU: begin
        aluRes   = {{(WIDTH-1){1'b0}}, flagC};
        aluFlags = {flagZ, flagN, flagC, flagV};
      end
      OP_AND:   aluRes = A & B;
      OP_OR:    aluRes = A | B;
      OP_XOR:   aluRes = A ^ B;
      default:  aluRes = '0;
    endcase
  end

  // Controller next-state. Single-cycle results land on the accept edge;
  // iterative ops park in MUL/DIV until the core's final step, then write
  // the output register. in_ready guarantees the output register is free
  // when that happens, so completion never has to wait on out_ready.
  always_comb begin
    state_d    = state_q;
    outValid_d = outValid_q && !out_ready;
    out_d      = out_q;
    flags_d    = flags_q;
    subStart   = 1'b0;
    subMode    = MD_MUL;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (isIterOp(op)) begin
            subStart = 1'b1;
            if (op == OP_MUL) begin
              subMode = MD_MUL;
              state_d = MUL;
            end else begin
              subMode = (op == OP_DIVU) ? MD_DIVU : MD_REMU;
              state_d = DIV;
            end
          end else begin
            out_d      = aluRes;
            flags_d    = aluFlags;
            outValid_d = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (subDone) begin
          out_d      = subResult;
          flags_d    = 4'b0000;
          outValid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller and output registers; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      out_q      <= '0;
      flags_q    <= 4'b0000;
    end else begin
      state_q    <= state_d;
      outValid_q <= outValid_d;
      out_q      <= out_d;
      flags_q    <= flags_d;
    end
  end

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) uIter (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (subStart),
    .mode_i   (subMode),
    .a_i      (A),
    .b_i      (B),
    .done_o   (subDone),
    .result_o (subResult)
  );

  assign out_valid    = outValid_q;
  assign Out          = out_q;
  assign {Z, N, C, V} = flags_q;

endmodule
